// File: rtl/keyscan_midi_bridge.sv
// keyscan_midi_bridge
//   Wishbone read-only initiator that drains key events from the keyboard
//   scanner FIFO and sends them as MIDI Note On/Off messages on a 31250-baud
//   8N1 UART line. No CPU is involved.
//
//   Optional build macro: KEYSCAN_MIDI_RUNNING_STATUS_EN
//     defined   : the last status byte sent is cached and a repeated status is
//                 not re-sent (2-byte message).
//     undefined : every message is 3 bytes.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | poll interval down-counter running while enable=1
//   ST_POLL  | single read of STATUS; bit1 = FIFO not empty
//   ST_EVT   | single read of EVENT; message bytes registered on ack
//   ST_TX0   | send status byte (skipped when running status matches)
//   ST_TX1   | send note byte
//   ST_TX2   | send velocity byte, then poll again immediately

module keyscan_midi_bridge #(
   parameter logic [31:0] WB_BASE      = 32'h3000_0000,
   parameter int          CLKS_PER_BIT = 1600,
   parameter int          POLL_DIV     = 1024,
   parameter int          ACK_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [3:0]  midi_chan,
   input  logic [6:0]  base_note,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        midi_tx,
   output logic        busy,
   output logic        bus_err
);

   localparam int BIT_TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int POLL_TW = (POLL_DIV > 1)     ? $clog2(POLL_DIV)     : 1;
   localparam int ACK_TW  = (ACK_TIMEOUT > 1)  ? $clog2(ACK_TIMEOUT)  : 1;

   localparam logic [BIT_TW-1:0]  BIT_RELOAD  = BIT_TW'(CLKS_PER_BIT - 1);
   localparam logic [POLL_TW-1:0] POLL_RELOAD = POLL_TW'(POLL_DIV - 1);
   localparam logic [ACK_TW-1:0]  ACK_RELOAD  = ACK_TW'(ACK_TIMEOUT - 1);

   localparam logic [31:0] ADR_STATUS = WB_BASE + 32'h0000_0004;
   localparam logic [31:0] ADR_EVENT  = WB_BASE + 32'h0000_0008;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POLL = 3'd1,
      ST_EVT  = 3'd2,
      ST_TX0  = 3'd3,
      ST_TX1  = 3'd4,
      ST_TX2  = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic [POLL_TW-1:0] poll_cnt;
   logic [ACK_TW-1:0]  ack_tmr;
   logic               tx_sent;
   logic [7:0]         msg_b0, msg_b1, msg_b2;

   logic               rd_start, ack_ok, tmo, build;
   logic               uart_load, uart_done, uart_active;
   logic [7:0]         uart_data;
   logic [BIT_TW-1:0]  bit_tmr;
   logic [3:0]         bit_idx;
   logic [8:0]         tx_shreg;

   logic [8:0]         note_sum;
   logic [6:0]         note_new, vel_new;
   logic [7:0]         status_new, b2_new;
   logic               skip_status;

   assign wb_we_o   = 1'b0;
   assign busy      = (state != ST_IDLE) || uart_active;
   assign uart_done = uart_active && (bit_tmr == '0) && (bit_idx == 4'd9);

   // Message bytes derived from the event word on the data bus.
   // The note sum is kept 9 bits wide so any carry still saturates to 127.
   always_comb begin
      note_sum   = 9'd0;
      note_new   = 7'd0;
      vel_new    = 7'd0;
      status_new = 8'h00;
      b2_new     = 8'h00;
      note_sum   = {2'b00, base_note} + {1'b0, wb_dat_i[7:0]};
      note_new   = (note_sum > 9'd127) ? 7'h7F : note_sum[6:0];
      if (wb_dat_i[15])
         vel_new = 7'h7F;
      else if (wb_dat_i[15:8] == 8'h00)
         vel_new = 7'h01;
      else
         vel_new = wb_dat_i[14:8];
      status_new = wb_dat_i[16] ? {4'h9, midi_chan} : {4'h8, midi_chan};
      b2_new     = wb_dat_i[16] ? {1'b0, vel_new} : 8'h40;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      rd_start  = 1'b0;
      build     = 1'b0;
      uart_load = 1'b0;
      uart_data = 8'h00;
      ack_ok    = wb_cyc_o && wb_ack_i;
      tmo       = wb_cyc_o && !wb_ack_i && (ack_tmr == '0);
      case (state)
         ST_IDLE: begin
            if (enable && (poll_cnt == '0))
               state_nxt = ST_POLL;
         end
         ST_POLL, ST_EVT: begin
            if (!wb_cyc_o) begin
               // First cycle in the state doubles as the idle gap between reads.
               if (!enable)
                  state_nxt = ST_IDLE;
               else
                  rd_start = 1'b1;
            end else if (ack_ok) begin
               if (!enable)
                  state_nxt = ST_IDLE;
               else if (state == ST_POLL)
                  state_nxt = wb_dat_i[1] ? ST_EVT : ST_IDLE;
               else if (wb_dat_i == 32'h0)
                  state_nxt = ST_IDLE;
               else begin
                  build     = 1'b1;
                  state_nxt = skip_status ? ST_TX1 : ST_TX0;
               end
            end else if (tmo) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_TX0, ST_TX1, ST_TX2: begin
            if (!tx_sent) begin
               if (!enable)
                  state_nxt = ST_IDLE;
               else begin
                  uart_load = 1'b1;
                  case (state)
                     ST_TX0:  uart_data = msg_b0;
                     ST_TX1:  uart_data = msg_b1;
                     default: uart_data = msg_b2;
                  endcase
               end
            end else if (uart_done) begin
               if (!enable)
                  state_nxt = ST_IDLE;
               else if (state == ST_TX0)
                  state_nxt = ST_TX1;
               else if (state == ST_TX1)
                  state_nxt = ST_TX2;
               else
                  state_nxt = ST_POLL;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Poll interval down-counter; reloaded whenever it is not actively counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         poll_cnt <= POLL_RELOAD;
      else if ((state == ST_IDLE) && enable) begin
         if (poll_cnt != '0)
            poll_cnt <= poll_cnt - POLL_TW'(1);
      end else
         poll_cnt <= POLL_RELOAD;
   end

   // Wishbone classic single read with ack timeout down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_adr_o <= 32'h0;
         ack_tmr  <= '0;
         bus_err  <= 1'b0;
      end else begin
         bus_err <= tmo;
         if (rd_start) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= (state == ST_POLL) ? ADR_STATUS : ADR_EVENT;
            ack_tmr  <= ACK_RELOAD;
         end else if (ack_ok || tmo) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
         end else if (wb_cyc_o && (ack_tmr != '0)) begin
            ack_tmr <= ack_tmr - ACK_TW'(1);
         end
      end
   end

   // Message bytes captured on the EVENT ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_b0 <= 8'h00;
         msg_b1 <= 8'h00;
         msg_b2 <= 8'h00;
      end else if (build) begin
         msg_b0 <= status_new;
         msg_b1 <= {1'b0, note_new};
         msg_b2 <= b2_new;
      end
   end

   // Marks that the current TX state has already handed its byte to the UART.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_sent <= 1'b0;
      else if (uart_load)
         tx_sent <= 1'b1;
      else if (uart_done)
         tx_sent <= 1'b0;
   end

   // UART transmitter: start bit, 8 data bits LSB first, stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         midi_tx     <= 1'b1;
         uart_active <= 1'b0;
         bit_tmr     <= '0;
         bit_idx     <= 4'd0;
         tx_shreg    <= 9'h1FF;
      end else if (uart_load) begin
         midi_tx     <= 1'b0;
         uart_active <= 1'b1;
         bit_tmr     <= BIT_RELOAD;
         bit_idx     <= 4'd0;
         tx_shreg    <= {1'b1, uart_data};
      end else if (uart_active) begin
         if (bit_tmr == '0) begin
            if (bit_idx == 4'd9)
               uart_active <= 1'b0;
            else begin
               midi_tx  <= tx_shreg[0];
               tx_shreg <= {1'b1, tx_shreg[8:1]};
               bit_idx  <= bit_idx + 4'd1;
               bit_tmr  <= BIT_RELOAD;
            end
         end else
            bit_tmr <= bit_tmr - BIT_TW'(1);
      end
   end

`ifdef KEYSCAN_MIDI_RUNNING_STATUS_EN
   logic       enable_q;
   logic       rs_valid;
   logic [7:0] rs_status;

   // Running-status cache; invalidated on enable falling and on bus errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q  <= 1'b0;
         rs_valid  <= 1'b0;
         rs_status <= 8'h00;
      end else begin
         enable_q <= enable;
         if ((enable_q && !enable) || tmo)
            rs_valid <= 1'b0;
         else if (uart_load && (state == ST_TX0)) begin
            rs_valid  <= 1'b1;
            rs_status <= msg_b0;
         end
      end
   end

   assign skip_status = rs_valid && (rs_status == status_new);
`else
   assign skip_status = 1'b0;
`endif

endmodule

// File: tb/tb_keyscan_midi_bridge.sv
// Self-checking bench for keyscan_midi_bridge: scanner slave model, UART
// receiver, Wishbone protocol monitor, vector table plus corner sequences.

module tb_keyscan_midi_bridge;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int CPB = 8;
   localparam int PDIV = 4;
   localparam int ATO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  midi_chan;
   logic [6:0]  base_note;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_i = 32'h0;
   logic        wb_ack_i = 1'b0;
   logic        midi_tx, busy, bus_err;

   int checks = 0;
   int errors = 0;
   int ferr = 0;
   int perr = 0;
   int be_cnt = 0;
   int ack_delay = 0;
   int wait_cnt = 0;
   logic status_force = 1'b0;
   logic prev_ack_cyc = 1'b0;

   logic [31:0] evq[$];
   logic [7:0]  rxq[$];

   typedef struct {
      string       name;
      logic [31:0] ev;
      logic [3:0]  chan;
      logic [6:0]  base;
      logic [7:0]  e0, e1, e2;
   } vec_t;
   vec_t vecs[8];

   keyscan_midi_bridge #(
      .WB_BASE(BASE), .CLKS_PER_BIT(CPB), .POLL_DIV(PDIV), .ACK_TIMEOUT(ATO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .midi_chan(midi_chan),
      .base_note(base_note), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .midi_tx(midi_tx), .busy(busy), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Scanner slave: acks after ack_delay extra cycles, EVENT pops the FIFO.
   always @(posedge clk) begin
      logic [31:0] ev;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
         if (wait_cnt == ack_delay) begin
            wb_ack_i <= 1'b1;
            wait_cnt <= 0;
            if (wb_adr_o == BASE + 32'h4)
               wb_dat_i <= ((evq.size() > 0) || status_force) ? 32'h2 : 32'h0;
            else if (wb_adr_o == BASE + 32'h8) begin
               ev = 32'h0;
               if (evq.size() > 0) ev = evq.pop_front();
               wb_dat_i <= ev;
            end else
               wb_dat_i <= 32'hDEAD_BEEF;
         end else
            wait_cnt <= wait_cnt + 1;
      end else begin
         wb_ack_i <= 1'b0;
         wait_cnt <= 0;
      end
   end

   // Protocol and bus_err observer.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (wb_cyc_o !== wb_stb_o) perr++;
         if (wb_we_o !== 1'b0) perr++;
         if (wb_cyc_o && !((wb_adr_o == BASE + 32'h4) || (wb_adr_o == BASE + 32'h8))) perr++;
         if (prev_ack_cyc && wb_cyc_o) perr++;
         if (bus_err) be_cnt++;
      end
      prev_ack_cyc = wb_cyc_o && wb_ack_i;
   end

   // UART receiver sampling mid-bit.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge midi_tx);
         repeat (CPB / 2) @(negedge clk);
         if (midi_tx !== 1'b0) ferr++;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = midi_tx;
         end
         repeat (CPB) @(negedge clk);
         if (midi_tx !== 1'b1) ferr++;
         rxq.push_back(b);
      end
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c = 0;
      while ((rxq.size() < n) && (c < budget)) begin
         @(negedge clk);
         c++;
      end
   endtask

   function automatic logic [31:0] get_byte(input int k);
      if (k < rxq.size()) return {24'h0, rxq[k]};
      return 32'hFFFF_FFFF;
   endfunction

   task automatic quiesce();
      enable = 1'b0;
      repeat (10) @(negedge clk);
      rxq.delete();
   endtask

   initial begin
      logic [7:0] rs_exp[$];
      int c, be0;

      vecs[0] = '{"note_on_basic",  32'h0001_6403, 4'h0, 7'd60,  8'h90, 8'h3F, 8'h64};
      vecs[1] = '{"note_off_ch3",   32'h0000_0005, 4'h3, 7'd60,  8'h83, 8'h41, 8'h40};
      vecs[2] = '{"note_saturate",  32'h0001_6464, 4'h0, 7'd60,  8'h90, 8'h7F, 8'h64};
      vecs[3] = '{"vel_zero",       32'h0001_0003, 4'h0, 7'd60,  8'h90, 8'h3F, 8'h01};
      vecs[4] = '{"vel_ff_chf",     32'h0001_FF10, 4'hF, 7'd0,   8'h9F, 8'h10, 8'h7F};
      vecs[5] = '{"vel_80_ts",      32'hAB01_8002, 4'h5, 7'd10,  8'h95, 8'h0C, 8'h7F};
      vecs[6] = '{"off_ts_ch9",     32'hAB00_7F07, 4'h9, 7'd20,  8'h89, 8'h1B, 8'h40};
      vecs[7] = '{"note_exact127",  32'h0000_203C, 4'h2, 7'd67,  8'h82, 8'h7F, 8'h40};

      rst_n = 1'b0; enable = 1'b0; midi_chan = 4'h0; base_note = 7'd60;
      repeat (3) @(negedge clk);
      chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
      chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
      chk("rst_we", {31'h0, wb_we_o}, 32'h0);
      chk("rst_adr", wb_adr_o, 32'h0);
      chk("rst_tx", {31'h0, midi_tx}, 32'h1);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Bit timing: 0x90 has four low data bits, so the line rises 5 bit times after start.
      evq.push_back(32'h0001_6403);
      enable = 1'b1;
      c = 0;
      while ((midi_tx !== 1'b0) && (c < 400)) begin @(negedge clk); c++; end
      c = 0;
      while ((midi_tx !== 1'b1) && (c < 400)) begin @(negedge clk); c++; end
      chk("start_to_rise", c, 5 * CPB);
      wait_bytes(3, 600);
      repeat (20) @(negedge clk);
      quiesce();

      for (int i = 0; i < 8; i++) begin
         midi_chan = vecs[i].chan;
         base_note = vecs[i].base;
         evq.push_back(vecs[i].ev);
         enable = 1'b1;
         wait_bytes(3, 600);
         repeat (50) @(negedge clk);
         chk({vecs[i].name, "_count"}, rxq.size(), 3);
         chk({vecs[i].name, "_b0"}, get_byte(0), {24'h0, vecs[i].e0});
         chk({vecs[i].name, "_b1"}, get_byte(1), {24'h0, vecs[i].e1});
         chk({vecs[i].name, "_b2"}, get_byte(2), {24'h0, vecs[i].e2});
         quiesce();
      end

      // Slave never acks: stb held exactly ACK_TIMEOUT cycles, one bus_err, no TX.
      ack_delay = 1000;
      be0 = be_cnt;
      enable = 1'b1;
      c = 0;
      while ((wb_stb_o !== 1'b1) && (c < 100)) begin @(negedge clk); c++; end
      c = 0;
      while ((wb_stb_o === 1'b1) && (c < 100)) begin
         if (midi_tx !== 1'b1) errors++;
         @(negedge clk); c++;
      end
      chk("tmo_stb_cycles", c, ATO);
      chk("tmo_bus_err_hi", {31'h0, bus_err}, 32'h1);
      chk("tmo_busy_idle", {31'h0, busy}, 32'h0);
      chk("tmo_cyc_low", {31'h0, wb_cyc_o}, 32'h0);
      @(negedge clk);
      chk("tmo_bus_err_pulse", be_cnt - be0, 1);
      chk("tmo_tx_idle", {31'h0, midi_tx}, 32'h1);
      quiesce();
      ack_delay = 0;
      repeat (5) @(negedge clk);

      // Ack in the last allowed cycle wins over the timeout.
      ack_delay = ATO - 2;
      be0 = be_cnt;
      midi_chan = 4'h0; base_note = 7'd60;
      evq.push_back(32'h0001_6403);
      enable = 1'b1;
      wait_bytes(3, 900);
      chk("late_ack_b0", get_byte(0), 32'h90);
      chk("late_ack_b2", get_byte(2), 32'h64);
      chk("late_ack_no_err", be_cnt - be0, 0);
      quiesce();
      ack_delay = 0;

      // FIFO-empty race: STATUS says not-empty but EVENT reads 0.
      status_force = 1'b1;
      enable = 1'b1;
      repeat (200) @(negedge clk);
      chk("zero_event_no_tx", rxq.size(), 0);
      status_force = 1'b0;
      quiesce();

      // Two presses on channel 0 back to back.
`ifdef KEYSCAN_MIDI_RUNNING_STATUS_EN
      rs_exp = '{8'h90, 8'h3F, 8'h64, 8'h40, 8'h64};
`else
      rs_exp = '{8'h90, 8'h3F, 8'h64, 8'h90, 8'h40, 8'h64};
`endif
      evq.push_back(32'h0001_6403);
      evq.push_back(32'h0001_6404);
      enable = 1'b1;
      wait_bytes(rs_exp.size(), 1500);
      repeat (50) @(negedge clk);
      chk("rs_count", rxq.size(), rs_exp.size());
      foreach (rs_exp[k]) chk($sformatf("rs_b%0d", k), get_byte(k), {24'h0, rs_exp[k]});
      quiesce();

      // enable falls during the note byte: that byte finishes, velocity dropped.
      evq.push_back(32'h0001_6403);
      enable = 1'b1;
      wait_bytes(1, 600);
      repeat (2 * CPB) @(negedge clk);
      enable = 1'b0;
      repeat (300) @(negedge clk);
      chk("endrop_count", rxq.size(), 2);
      chk("endrop_b1", get_byte(1), 32'h3F);
      chk("endrop_busy", {31'h0, busy}, 32'h0);
      quiesce();

      // Reset in the middle of data bit 3 of the status byte.
      evq.push_back(32'h0001_6403);
      enable = 1'b1;
      c = 0;
      while ((midi_tx !== 1'b0) && (c < 400)) begin @(negedge clk); c++; end
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      chk("mid_bit3_low", {31'h0, midi_tx}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_tx", {31'h0, midi_tx}, 32'h1);
      chk("rst_async_cyc", {31'h0, wb_cyc_o}, 32'h0);
      chk("rst_async_busy", {31'h0, busy}, 32'h0);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      rxq.delete();
      evq.push_back(32'h0001_6403);
      enable = 1'b1;
      wait_bytes(3, 600);
      chk("post_rst_b0", get_byte(0), 32'h90);
      chk("post_rst_b1", get_byte(1), 32'h3F);
      chk("post_rst_b2", get_byte(2), 32'h64);
      quiesce();

      chk("wb_protocol", perr, 0);
      chk("uart_framing", ferr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
